// File: rtl/mu0_control_pkg.sv
// Shared MU0 control definitions: FSM states, opcodes, ALU function codes
// and the packed control word driven towards the datapath.
package mu0_control_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StExec  = 2'd2,
    StHalt  = 2'd3
  } state_e;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JGE = 4'h5;
  localparam logic [3:0] OP_JNE = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;

  localparam logic [1:0] ALU_FS_Y   = 2'b00;
  localparam logic [1:0] ALU_FS_ADD = 2'b01;
  localparam logic [1:0] ALU_FS_SUB = 2'b10;
  localparam logic [1:0] ALU_FS_INC = 2'b11;

  typedef struct packed {
    logic       x_sel;
    logic       y_sel;
    logic       addr_sel;
    logic [1:0] alu_fs;
    logic       acc_ce;
    logic       pc_ce;
    logic       ir_ce;
    logic       acc_oe;
    logic       mem_rd;
    logic       mem_wr;
  } ctrl_t;

endpackage

// File: rtl/mu0_control_decode.sv
// Combinational MU0 decoder: (state, opcode, ACC flags, mem_rdy) -> control word.
// Register enables of memory ops fire only in the cycle memory completes.
module mu0_control_decode
  import mu0_control_pkg::*;
(
  input  state_e     state,
  input  logic [3:0] opcode,
  input  logic       acc_z,
  input  logic       acc_n,
  input  logic       mem_rdy,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      StFetch: begin
        ctrl.x_sel  = 1'b1;
        ctrl.alu_fs = ALU_FS_INC;
        ctrl.mem_rd = 1'b1;
        ctrl.ir_ce  = mem_rdy;
        ctrl.pc_ce  = mem_rdy;
      end
      StExec: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            ctrl.addr_sel = 1'b1;
            ctrl.mem_rd   = 1'b1;
            ctrl.acc_ce   = mem_rdy;
            ctrl.alu_fs   = (opcode == OP_LDA) ? ALU_FS_Y :
                            (opcode == OP_ADD) ? ALU_FS_ADD : ALU_FS_SUB;
          end
          OP_STA: begin
            ctrl.addr_sel = 1'b1;
            ctrl.mem_wr   = 1'b1;
            ctrl.acc_oe   = 1'b1;
          end
          OP_JMP, OP_JGE, OP_JNE: begin
            ctrl.y_sel  = 1'b1;
            ctrl.alu_fs = ALU_FS_Y;
            ctrl.pc_ce  = (opcode == OP_JMP) ? 1'b1 :
                          (opcode == OP_JGE) ? ~acc_n : ~acc_z;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mu0_control.sv
// MU0 control FSM: fetch/execute sequencing, memory wait watchdog,
// sticky error flags and retired-instruction counter.
module mu0_control
  import mu0_control_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic [3:0]       opcode,
  input  logic             acc_z,
  input  logic             acc_n,
  input  logic             mem_rdy,
  output logic             x_sel,
  output logic             y_sel,
  output logic             addr_sel,
  output logic [1:0]       alu_fs,
  output logic             acc_ce,
  output logic             pc_ce,
  output logic             ir_ce,
  output logic             acc_oe,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             halted,
  output logic             bus_err,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  // Counter only needs to hold 0..MEM_TIMEOUT-1; the last wait cycle times out.
  localparam int unsigned WaitW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             bus_err_q, bus_err_d;
  logic             illegal_q, illegal_d;
  ctrl_t            ctrl;
  logic             stall, timeout;

  mu0_control_decode u_decode (
    .state   (state_q),
    .opcode  (opcode),
    .acc_z   (acc_z),
    .acc_n   (acc_n),
    .mem_rdy (mem_rdy),
    .ctrl    (ctrl)
  );

  assign stall   = (ctrl.mem_rd | ctrl.mem_wr) & ~mem_rdy;
  assign timeout = (MEM_TIMEOUT != 0) && stall && (wcnt_q == WaitW'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    wcnt_d    = '0;
    count_d   = count_q;
    bus_err_d = bus_err_q;
    illegal_d = illegal_q;
    if (stall && !timeout) wcnt_d = wcnt_q + 1'b1;
    unique case (state_q)
      StIdle, StHalt: begin
        if (run) begin
          state_d   = StFetch;
          bus_err_d = 1'b0;
          illegal_d = 1'b0;
        end
      end
      StFetch: begin
        if (timeout) begin
          state_d   = StHalt;
          bus_err_d = 1'b1;
        end else if (mem_rdy) begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (opcode[3]) begin
          state_d   = StHalt;
          illegal_d = 1'b1;
        end else if (timeout) begin
          state_d   = StHalt;
          bus_err_d = 1'b1;
        end else if (!stall) begin
          state_d = (opcode == OP_STP) ? StHalt : StFetch;
          count_d = count_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      wcnt_q    <= '0;
      count_q   <= '0;
      bus_err_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      count_q   <= count_d;
      bus_err_q <= bus_err_d;
      illegal_q <= illegal_d;
    end
  end

  assign x_sel       = ctrl.x_sel;
  assign y_sel       = ctrl.y_sel;
  assign addr_sel    = ctrl.addr_sel;
  assign alu_fs      = ctrl.alu_fs;
  assign acc_ce      = ctrl.acc_ce;
  assign pc_ce       = ctrl.pc_ce;
  assign ir_ce       = ctrl.ir_ce;
  assign acc_oe      = ctrl.acc_oe;
  assign mem_rd      = ctrl.mem_rd;
  assign mem_wr      = ctrl.mem_wr;
  assign halted      = (state_q == StHalt);
  assign bus_err     = bus_err_q;
  assign illegal     = illegal_q;
  assign instr_count = count_q;

endmodule
